hsid_pixel_scheduler: RTL
=========================

// Module: hsid_pixel_scheduler
// PURPOSE
//  Job-level sequencer for the HSI library-search core (hsid_main). Accepts one job command
//  (pixel count, library size, band-pack threshold) and launches one core run per pixel.
//  Per run it holds the core config stable, pulses start and waits for done. It then captures
//  the best-match reference index and MSE and emits one result per pixel on a valid/ready port.
//  Sits between the bus-side register file and hsid_main.
// PARAMETERS
//  HSP_LIBRARY_WIDTH    HSID_HSP_LIBRARY_WIDTH  bits of library size / ref index
//  HSP_BAND_PACK_WIDTH  HSID_HSP_BANDS_WIDTH-1  bits of band-pack threshold
//  MSE_WIDTH            HSID_MSE_WIDTH          bits of MSE value
//  PIXEL_COUNT_WIDTH    16                      bits of pixel count / pixel index
//  TIMEOUT_WIDTH        20                      watchdog counter bits (HSID_SCHED_TIMEOUT_EN only)
// PORTS
//  clk                 in   1     clock
//  rst_n               in   1     asynchronous reset, active-low
//  cfg_valid/cfg_ready in/out 1   job command handshake
//  cfg_pixel_count     in   PCW   pixels in job (0 legal)
//  cfg_library_size    in   HLW   references per pixel
//  cfg_band_threshold  in   HBW   band packs per reference
//  abort               in   1     level; terminate current job
//  main_start          out  1     1-cycle start pulse to core
//  main_library_size   out  HLW   latched cfg, stable while busy
//  main_band_threshold out  HBW   latched cfg, stable while busy
//  main_idle/main_done in   1     core status (done = 1-cycle pulse)
//  main_min_ref        in   HLW   core best-match index, valid with main_done
//  main_min_mse        in   MSE_WIDTH  core best MSE, valid with main_done
//  res_valid/res_ready out/in 1   per-pixel result handshake
//  res_pixel_idx       out  PCW   pixel index of result
//  res_min_ref/res_min_mse out HLW/MSE_WIDTH  captured result
//  busy                out  1     state != S_IDLE
//  job_done            out  1     1-cycle pulse at job end
//  job_aborted/job_error out 1    status flags, valid with job_done
// BEHAVIOUR
//  Reset: state S_IDLE. All outputs 0, except cfg_ready = 1. Latched cfg and counters = 0.
//  S_IDLE: cfg_ready=1. On cfg_valid, latch cfg and clear pixel_idx, aborted and error.
//    pixel_count==0 -> S_FINISH; otherwise -> S_LAUNCH. abort is ignored in S_IDLE.
//  S_LAUNCH: if main_idle, assert main_start for exactly one cycle -> S_RUN; else hold.
//  S_RUN: on main_done, capture min_ref/min_mse into result regs -> S_RESULT.
//  S_RESULT: res_valid=1. Data is held stable until res_ready.
//    On handshake: if pixel_idx==pixel_count-1 -> S_FINISH; else pixel_idx++ -> S_LAUNCH.
//  S_FINISH: job_done=1 for one cycle -> S_IDLE. Flags hold until next cfg accept.
//  Latency: cfg accept -> main_start = 2 cycles (core idle); main_done -> res_valid = 1 cycle.
//  Abort in S_LAUNCH or S_RESULT: go to S_FINISH next cycle with aborted=1.
//    A pending result is dropped and no main_start is issued.
//  Abort in S_RUN: the core cannot be cancelled. Wait for main_done, discard the result
//    (no res_valid), then go to S_FINISH with aborted=1.
//  Abort and main_done in the same S_RUN cycle: treated as abort; result discarded.
//  cfg_valid while busy: cfg_ready=0; the command waits.
//  pixel_idx counts without wrap; max pixel_count = 2^PCW-1.
//  Async reset mid-job returns to S_IDLE immediately; the core is reset by the same rst_n.
// CONFIGURATION
//  `HSID_SCHED_TIMEOUT_EN defined: watchdog counts S_RUN cycles. It clears on entry to S_RUN.
//    Reaching 2^TIMEOUT_WIDTH-1 without main_done -> error=1 and S_FINISH.
//    A later stray main_done is ignored.
//  Macro undefined: no counter; job_error tied 0; S_RUN waits indefinitely.
// STRUCTURE
//  hsid_pkg: hsid_sched_state_t {S_IDLE,S_LAUNCH,S_RUN,S_RESULT,S_FINISH} and
//    HSID_SCHED_PIXEL_COUNT_WIDTH constant.
//  Sub-module hsid_watchdog (clear, enable, expired) is instantiated only under the macro.
//    Everything else is a single FSM and datapath in this module.
// TESTING
//  T1 basic: pixels=3, lib=4, thr=2; core done after 10 cycles with ref 1/2/3, mse 5/6/7
//     -> 3 results idx 0,1,2 with matching ref/mse; 3 main_start pulses; one job_done, flags 0.
//  T2 zero job: pixels=0 -> no main_start, no res_valid, job_done 2 cycles after cfg accept.
//  T3 backpressure: res_ready low 20 cycles -> res_* stable; no new main_start until accept.
//  T4 abort in S_RUN: pixels=5, abort at pixel 2 mid-run -> waits for done; results only
//     for idx 0,1; job_done with aborted=1; next cfg accepted normally.
//  T5 core busy: main_idle=0 for 8 cycles at launch -> main_start delayed until main_idle=1.
//  T6 timeout (macro on, TIMEOUT_WIDTH=4): core never done -> job_error=1 after 15 S_RUN
//     cycles, job_done pulse; macro off -> scheduler stays in S_RUN, busy=1.

Source files
------------

// File: rtl/hsid_pixel_scheduler_pkg.sv
// Shared types and width constants for the HSI pixel scheduler.
// The watchdog build option is HSID_SCHED_TIMEOUT_EN.
package hsid_pixel_scheduler_pkg;

    localparam int HSID_HSP_LIBRARY_WIDTH       = 10;
    localparam int HSID_HSP_BANDS_WIDTH         = 6;
    localparam int HSID_MSE_WIDTH               = 24;
    localparam int HSID_SCHED_PIXEL_COUNT_WIDTH = 16;
    localparam int HSID_SCHED_TIMEOUT_WIDTH     = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_RESULT,
        S_FINISH
    } hsid_sched_state_t;

endpackage

// File: rtl/hsid_pixel_scheduler_if.sv
// Job command, core control and per-pixel result bundle of the scheduler.
// slave = scheduler side, master = register file / core / result sink side.
interface hsid_pixel_scheduler_if
    import hsid_pixel_scheduler_pkg::*;
#(
    parameter int HLW  = HSID_HSP_LIBRARY_WIDTH,
    parameter int HBW  = HSID_HSP_BANDS_WIDTH - 1,
    parameter int MSEW = HSID_MSE_WIDTH,
    parameter int PCW  = HSID_SCHED_PIXEL_COUNT_WIDTH
) ();

    logic            cfg_valid;
    logic            cfg_ready;
    logic [PCW-1:0]  cfg_pixel_count;
    logic [HLW-1:0]  cfg_library_size;
    logic [HBW-1:0]  cfg_band_threshold;
    logic            abort;

    logic            main_start;
    logic [HLW-1:0]  main_library_size;
    logic [HBW-1:0]  main_band_threshold;
    logic            main_idle;
    logic            main_done;
    logic [HLW-1:0]  main_min_ref;
    logic [MSEW-1:0] main_min_mse;

    logic            res_valid;
    logic            res_ready;
    logic [PCW-1:0]  res_pixel_idx;
    logic [HLW-1:0]  res_min_ref;
    logic [MSEW-1:0] res_min_mse;

    logic            busy;
    logic            job_done;
    logic            job_aborted;
    logic            job_error;

    modport slave (
        input  cfg_valid, cfg_pixel_count, cfg_library_size,
        input  cfg_band_threshold, abort,
        input  main_idle, main_done, main_min_ref, main_min_mse,
        input  res_ready,
        output cfg_ready, main_start, main_library_size,
        output main_band_threshold,
        output res_valid, res_pixel_idx, res_min_ref, res_min_mse,
        output busy, job_done, job_aborted, job_error
    );

    modport master (
        output cfg_valid, cfg_pixel_count, cfg_library_size,
        output cfg_band_threshold, abort,
        output main_idle, main_done, main_min_ref, main_min_mse,
        output res_ready,
        input  cfg_ready, main_start, main_library_size,
        input  main_band_threshold,
        input  res_valid, res_pixel_idx, res_min_ref, res_min_mse,
        input  busy, job_done, job_aborted, job_error
    );

endinterface

// File: rtl/hsid_pixel_scheduler_watchdog.sv
// Core-run watchdog; used only when HSID_SCHED_TIMEOUT_EN is defined.
// Flags the enabled cycle in which the run count reaches 2^WIDTH-1.
module hsid_watchdog #(
    parameter int WIDTH = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [WIDTH-1:0] LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/hsid_pixel_scheduler.sv
// Job-level sequencer for hsid_main: one core run and one result per pixel.
// Define HSID_SCHED_TIMEOUT_EN to add a watchdog on each core run.
module hsid_pixel_scheduler
    import hsid_pixel_scheduler_pkg::*;
#(
    parameter int HSP_LIBRARY_WIDTH   = HSID_HSP_LIBRARY_WIDTH,
    parameter int HSP_BAND_PACK_WIDTH = HSID_HSP_BANDS_WIDTH - 1,
    parameter int MSE_WIDTH           = HSID_MSE_WIDTH,
    parameter int PIXEL_COUNT_WIDTH   = HSID_SCHED_PIXEL_COUNT_WIDTH,
    parameter int TIMEOUT_WIDTH       = HSID_SCHED_TIMEOUT_WIDTH
) (
    input logic                   clk,
    input logic                   rst_n,
    hsid_pixel_scheduler_if.slave bus
);

    localparam int PCW = PIXEL_COUNT_WIDTH;

    hsid_sched_state_t state_q, state_d;

    logic [PCW-1:0]                 count_q, count_d;
    logic [PCW-1:0]                 idx_q, idx_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   lib_q, lib_d;
    logic [HSP_BAND_PACK_WIDTH-1:0] thr_q, thr_d;
    logic [HSP_LIBRARY_WIDTH-1:0]   ref_q, ref_d;
    logic [MSE_WIDTH-1:0]           mse_q, mse_d;
    logic                           aborted_q, aborted_d;
    logic                           start_q, start_d;
    logic                           done_q;
    logic                           accept;
    logic                           timeout;

    assign accept = (state_q == S_IDLE) && bus.cfg_valid;

`ifdef HSID_SCHED_TIMEOUT_EN
    logic wd_expired;
    logic error_q;

    hsid_watchdog #(
        .WIDTH(TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (start_d),
        .enable_i (state_q == S_RUN),
        .expired_o(wd_expired)
    );

    // A done arriving in the expiry cycle still wins over the watchdog.
    assign timeout = (state_q == S_RUN) && !bus.main_done && wd_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (timeout) begin
            error_q <= 1'b1;
        end
    end

    assign bus.job_error = error_q;
`else
    assign timeout       = 1'b0;
    assign bus.job_error = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        lib_d     = lib_q;
        thr_d     = thr_q;
        ref_d     = ref_q;
        mse_d     = mse_q;
        aborted_d = aborted_q;
        start_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    count_d   = bus.cfg_pixel_count;
                    lib_d     = bus.cfg_library_size;
                    thr_d     = bus.cfg_band_threshold;
                    idx_d     = '0;
                    aborted_d = 1'b0;
                    state_d   = (bus.cfg_pixel_count == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else if (bus.main_idle) begin
                    start_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // The core cannot be cancelled: remember the abort, drain the run.
                if (bus.abort) begin
                    aborted_d = 1'b1;
                end
                if (bus.main_done) begin
                    if (bus.abort || aborted_q) begin
                        state_d = S_FINISH;
                    end else begin
                        ref_d   = bus.main_min_ref;
                        mse_d   = bus.main_min_mse;
                        state_d = S_RESULT;
                    end
                end else if (timeout) begin
                    state_d = S_FINISH;
                end
            end
            S_RESULT: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else if (bus.res_ready) begin
                    if (idx_q == count_q - PCW'(1)) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + PCW'(1);
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            idx_q     <= '0;
            lib_q     <= '0;
            thr_q     <= '0;
            ref_q     <= '0;
            mse_q     <= '0;
            aborted_q <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            lib_q     <= lib_d;
            thr_q     <= thr_d;
            ref_q     <= ref_d;
            mse_q     <= mse_d;
            aborted_q <= aborted_d;
            start_q   <= start_d;
            done_q    <= (state_q == S_FINISH);
        end
    end

    assign bus.cfg_ready           = (state_q == S_IDLE);
    assign bus.main_start          = start_q;
    assign bus.main_library_size   = lib_q;
    assign bus.main_band_threshold = thr_q;
    // An abort in the result cycle drops the pending result, no handshake.
    assign bus.res_valid           = (state_q == S_RESULT) && !bus.abort;
    assign bus.res_pixel_idx       = idx_q;
    assign bus.res_min_ref         = ref_q;
    assign bus.res_min_mse         = mse_q;
    assign bus.busy                = (state_q != S_IDLE);
    assign bus.job_done            = done_q;
    assign bus.job_aborted         = aborted_q;

endmodule
